// File: rtl/univ_shift_collector_pkg.sv
// Shared definitions for the universal rotate register and its serial collector.
// Holds the 2-bit ctrl encoding and the output-buffer state encoding.
package univ_shift_collector_pkg;

    localparam logic [1:0] CTRL_CLEAR = 2'b00;
    localparam logic [1:0] CTRL_SHL   = 2'b10;
    localparam logic [1:0] CTRL_SHR   = 2'b01;
    localparam logic [1:0] CTRL_HOLD  = 2'b11;

    typedef enum logic {
        OBUF_EMPTY = 1'b0,
        OBUF_FULL  = 1'b1
    } obuf_state_e;

endpackage

// File: rtl/univ_collector_obuf.sv
// Double-buffered output register for completed words.
// Provides a valid/ack handshake and a sticky overrun flag.
module univ_collector_obuf
    import univ_shift_collector_pkg::*;
#(
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          async_rst,
    input  logic          clear,
    input  logic          word_done,
    input  logic [DW-1:0] word_in,
    input  logic          q_ack,
    output logic [DW-1:0] q,
    output logic          q_valid,
    output logic          overrun
);

    obuf_state_e state_q, state_d;
    logic        load;
    logic        ovr_set;

    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            state_q <= OBUF_EMPTY;
            q       <= '0;
            overrun <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load) begin
                q <= word_in;
            end
            if (clear) begin
                overrun <= 1'b0;
            end else if (ovr_set) begin
                overrun <= 1'b1;
            end
        end
    end

    // An ack arriving on the same edge as a completion frees the slot for the new word.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        ovr_set = 1'b0;
        case (state_q)
            OBUF_EMPTY: begin
                if (word_done) begin
                    load    = 1'b1;
                    state_d = OBUF_FULL;
                end
            end
            OBUF_FULL: begin
                if (word_done) begin
                    if (q_ack) begin
                        load = 1'b1;
                    end else begin
                        ovr_set = 1'b1;
                    end
                end else if (q_ack) begin
                    state_d = OBUF_EMPTY;
                end
            end
            default: state_d = OBUF_EMPTY;
        endcase
    end

    assign q_valid = (state_q == OBUF_FULL);

endmodule

// File: rtl/univ_shift_collector.sv
// Rebuilds DW-bit words from the serial stream of a universal rotate register.
// MSB-first on shift-left-in, LSB-first on shift-right-in; completed words go to the output buffer.
module univ_shift_collector
    import univ_shift_collector_pkg::*;
#(
    parameter int DW = 4,
    localparam int CW = $clog2(DW + 1)
) (
    input  logic          clk,
    input  logic          async_rst,
    input  logic [1:0]    ctrl,
    input  logic          serial_in,
    output logic [DW-1:0] q,
    output logic          q_valid,
    input  logic          q_ack,
    output logic          overrun,
    output logic [CW-1:0] bit_cnt
);

    logic [DW-1:0] sr;
    logic [DW-1:0] sr_next;
    logic          shifting;
    logic          word_done;
    logic          clear;

    always_comb begin
        sr_next  = sr;
        shifting = 1'b0;
        case (ctrl)
            CTRL_SHL: begin
                sr_next  = {sr[DW-2:0], serial_in};
                shifting = 1'b1;
            end
            CTRL_SHR: begin
                sr_next  = {serial_in, sr[DW-1:1]};
                shifting = 1'b1;
            end
            default: begin
                sr_next  = sr;
                shifting = 1'b0;
            end
        endcase
    end

    assign clear     = (ctrl == CTRL_CLEAR);
    assign word_done = shifting && (bit_cnt == CW'(DW - 1));

    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            sr      <= '0;
            bit_cnt <= '0;
        end else if (clear || word_done) begin
            sr      <= '0;
            bit_cnt <= '0;
        end else if (shifting) begin
            sr      <= sr_next;
            bit_cnt <= bit_cnt + 1'b1;
        end
    end

    univ_collector_obuf #(
        .DW (DW)
    ) u_obuf (
        .clk       (clk),
        .async_rst (async_rst),
        .clear     (clear),
        .word_done (word_done),
        .word_in   (sr_next),
        .q_ack     (q_ack),
        .q         (q),
        .q_valid   (q_valid),
        .overrun   (overrun)
    );

endmodule
